// File: rtl/ste_dma_snd_ctrl.sv
// STE DMA sound frame controller: CPU register file at $FF8900-$FF8913 plus the
// fetch/load sequencer that feeds the shifter's audio FIFO from RAM.
module ste_dma_snd_ctrl #(
    parameter int AW = 23
) (
    input  logic          clk32,
    input  logic          resb,
    input  logic          CS,
    input  logic          RW,
    input  logic [3:0]    A,
    input  logic [15:0]   DIN,
    output logic [15:0]   DOUT,
    input  logic          SREQ,
    output logic          SLOAD_N,
    output logic          mem_req,
    input  logic          mem_ack,
    output logic [AW-1:0] snd_addr,
    output logic          snd_active,
    output logic          snd_int
);

    typedef enum logic [2:0] {S_IDLE, S_CHK, S_REQ, S_LOAD, S_END} state_t;

    state_t        state;
    state_t        state_nx;
    logic          play;
    logic          loop;
    logic [22:0]   start_w;
    logic [22:0]   end_w;
    logic [AW-1:0] cnt;
    logic [AW-1:0] fend;
    logic          discard;
    logic          wr;
    logic          load_frame;
    logic          cnt_inc;
    logic          play_clr;
    logic          discard_set;
    logic [22:0]   cnt_w;
    logic [7:0]    rd_byte;
    logic          unused_din;

    assign wr         = CS & ~RW;
    assign unused_din = ^DIN[15:8];
    assign cnt_w      = 23'(cnt);

    // Shadow frame bounds are word addresses; the lo byte carries bits 7:1 of the byte address.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            play    <= 1'b0;
            loop    <= 1'b0;
            start_w <= '0;
            end_w   <= '0;
        end else begin
            if (play_clr)
                play <= 1'b0;
            if (wr) begin
                case (A)
                    4'd0: begin
                        play <= DIN[0];
                        loop <= DIN[1];
                    end
                    4'd1: start_w[22:15] <= DIN[7:0];
                    4'd2: start_w[14:7]  <= DIN[7:0];
                    4'd3: start_w[6:0]   <= DIN[7:1];
                    4'd7: end_w[22:15]   <= DIN[7:0];
                    4'd8: end_w[14:7]    <= DIN[7:0];
                    4'd9: end_w[6:0]     <= DIN[7:1];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state   <= S_IDLE;
            cnt     <= '0;
            fend    <= '0;
            discard <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_frame) begin
                cnt  <= AW'(start_w);
                fend <= AW'(end_w);
            end else if (cnt_inc) begin
                cnt <= cnt + AW'(1);
            end
            if (discard_set)
                discard <= 1'b1;
            else if (state == S_LOAD)
                discard <= 1'b0;
        end
    end

    // A bus cycle, once requested, always completes; a stop during it only drops the word.
    always_comb begin
        state_nx    = state;
        load_frame  = 1'b0;
        cnt_inc     = 1'b0;
        play_clr    = 1'b0;
        discard_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (play) begin
                    load_frame = 1'b1;
                    state_nx   = S_CHK;
                end
            end
            S_CHK: begin
                if (!play)
                    state_nx = S_IDLE;
                else if (cnt == fend)
                    state_nx = S_END;
                else if (SREQ)
                    state_nx = S_REQ;
            end
            S_REQ: begin
                if (!play)
                    discard_set = 1'b1;
                if (mem_ack)
                    state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (discard) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_inc  = 1'b1;
                    state_nx = S_CHK;
                end
            end
            S_END: begin
                if (!play) begin
                    state_nx = S_IDLE;
                end else if (loop) begin
                    load_frame = 1'b1;
                    state_nx   = S_CHK;
                end else begin
                    play_clr = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem_req    = (state == S_REQ);
    assign SLOAD_N    = ~((state == S_LOAD) && !discard);
    assign snd_int    = (state == S_END) && play;
    assign snd_active = (state != S_IDLE);
    assign snd_addr   = cnt;

    always_comb begin
        rd_byte = 8'h00;
        case (A)
            4'd0: rd_byte = {6'b0, loop, play};
            4'd1: rd_byte = start_w[22:15];
            4'd2: rd_byte = start_w[14:7];
            4'd3: rd_byte = {start_w[6:0], 1'b0};
            4'd4: rd_byte = cnt_w[22:15];
            4'd5: rd_byte = cnt_w[14:7];
            4'd6: rd_byte = {cnt_w[6:0], 1'b0};
            4'd7: rd_byte = end_w[22:15];
            4'd8: rd_byte = end_w[14:7];
            4'd9: rd_byte = {end_w[6:0], 1'b0};
            default: rd_byte = 8'h00;
        endcase
    end

    assign DOUT = (CS && RW) ? {8'h00, rd_byte} : 16'h0000;

endmodule

// File: tb/tb_ste_dma_snd_ctrl.sv
// Bench for ste_dma_snd_ctrl: frames are expanded into an ordered list of expected
// FIFO loads and interrupts, which a monitor scores as the DUT produces them.
`timescale 1ns/1ps
module tb_ste_dma_snd_ctrl;

    localparam int AW = 23;

    logic          clk32 = 1'b0;
    logic          resb;
    logic          CS;
    logic          RW;
    logic [3:0]    A;
    logic [15:0]   DIN;
    logic [15:0]   DOUT;
    logic          SREQ = 1'b1;
    logic          SLOAD_N;
    logic          mem_req;
    logic          mem_ack;
    logic [AW-1:0] snd_addr;
    logic          snd_active;
    logic          snd_int;

    typedef struct {
        bit          is_int;
        logic [22:0] addr;
    } ev_t;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   loads_seen = 0;
    int   ints_seen = 0;
    int   req_cycles = 0;
    bit   free_int = 1'b0;
    bit   sreq_rand = 1'b0;
    logic sreq_level = 1'b1;
    int   ack_force = -1;

    always #5 clk32 = ~clk32;

    ste_dma_snd_ctrl #(.AW(AW)) dut (
        .clk32(clk32), .resb(resb), .CS(CS), .RW(RW), .A(A), .DIN(DIN), .DOUT(DOUT),
        .SREQ(SREQ), .SLOAD_N(SLOAD_N), .mem_req(mem_req), .mem_ack(mem_ack),
        .snd_addr(snd_addr), .snd_active(snd_active), .snd_int(snd_int)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic bit head_is(input bit is_int);
        return (exp_q.size() > 0) && (exp_q[0].is_int == is_int);
    endfunction

    // A one-shot frame is every word from start up to (not including) end, mod 2^23, then one interrupt.
    function automatic void push_frame(input logic [22:0] s, input logic [22:0] e);
        ev_t         ev;
        logic [22:0] w;
        w = s;
        while (w != e) begin
            ev.is_int = 1'b0;
            ev.addr   = w;
            exp_q.push_back(ev);
            w = w + 23'd1;
        end
        ev.is_int = 1'b1;
        ev.addr   = '0;
        exp_q.push_back(ev);
    endfunction

    always @(negedge clk32) SREQ = sreq_rand ? 1'($urandom_range(0, 1)) : sreq_level;

    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk32);
            if (mem_req) begin
                int d;
                d = (ack_force >= 0) ? ack_force : int'($urandom_range(0, 3));
                repeat (d) @(negedge clk32);
                mem_ack = 1'b1;
                @(negedge clk32);
                mem_ack = 1'b0;
            end
        end
    end

    always @(negedge clk32) begin
        if (resb) begin
            if (mem_req)
                req_cycles++;
            if (mem_req && mem_ack && head_is(1'b0))
                check_output("fetch_addr", 32'(snd_addr), 32'(exp_q[0].addr));
            if (!SLOAD_N) begin
                loads_seen++;
                check_output("load_expected", 32'(head_is(1'b0)), 32'd1);
                if (head_is(1'b0)) begin
                    check_output("load_addr", 32'(snd_addr), 32'(exp_q[0].addr));
                    void'(exp_q.pop_front());
                end
            end
            if (snd_int) begin
                ints_seen++;
                if (!free_int) begin
                    check_output("int_expected", 32'(head_is(1'b1)), 32'd1);
                    if (head_is(1'b1))
                        void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk32);
        CS = 1'b1; RW = 1'b0; A = a; DIN = {8'hA5, d};
        @(negedge clk32);
        CS = 1'b0; RW = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk32);
        CS = 1'b1; RW = 1'b1; A = a;
        #1 d = DOUT;
        CS = 1'b0;
    endtask

    task automatic read_addr(input logic [3:0] base, output logic [23:0] v);
        logic [15:0] d;
        cpu_read(base, d);
        v[23:16] = d[7:0];
        cpu_read(base + 4'd1, d);
        v[15:8] = d[7:0];
        cpu_read(base + 4'd2, d);
        v[7:0] = d[7:0];
    endtask

    task automatic apply_stimulus(input logic [22:0] s, input logic [22:0] e);
        logic [23:0] sb;
        logic [23:0] eb;
        sb = {s, 1'b0};
        eb = {e, 1'b0};
        cpu_write(4'd1, sb[23:16]);
        cpu_write(4'd2, sb[15:8]);
        cpu_write(4'd3, sb[7:0]);
        cpu_write(4'd7, eb[23:16]);
        cpu_write(4'd8, eb[15:8]);
        cpu_write(4'd9, eb[7:0]);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk32);
        while (snd_active && n < 3000) begin
            @(negedge clk32);
            n++;
        end
        check_output({name, "_idle"}, 32'(snd_active), 32'd0);
        @(negedge clk32);
        check_output({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic [23:0] v;
        logic [23:0] v2;
        logic [22:0] s;
        logic [22:0] e;
        int          base;
        int          n;
        int          r0;

        CS = 1'b0; RW = 1'b1; A = 4'd0; DIN = 16'h0000; resb = 1'b0;
        repeat (3) @(negedge clk32);
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_sload_n", 32'(SLOAD_N), 32'd1);
        check_output("rst_active", 32'(snd_active), 32'd0);
        check_output("rst_int", 32'(snd_int), 32'd0);
        check_output("rst_addr", 32'(snd_addr), 32'd0);
        resb = 1'b1;
        cpu_read(4'd0, d);
        check_output("rst_ctrl", 32'(d), 32'd0);
        check_output("dout_no_cs", 32'(DOUT), 32'd0);

        s = 23'($urandom);
        e = 23'($urandom);
        apply_stimulus(s, e);
        read_addr(4'd1, v);
        check_output("start_readback", 32'(v), 32'({s, 1'b0}));
        read_addr(4'd7, v);
        check_output("end_readback", 32'(v), 32'({e, 1'b0}));
        cpu_read(4'd7, d);
        check_output("read_high_byte", 32'(d[15:8]), 32'd0);
        cpu_write(4'd4, 8'hFF);
        cpu_write(4'd5, 8'hFF);
        cpu_write(4'd6, 8'hFF);
        read_addr(4'd4, v);
        check_output("cnt_write_ignored", 32'(v), 32'd0);
        cpu_write(4'd11, 8'h5A);
        cpu_read(4'd11, d);
        check_output("unmapped_read", 32'(d), 32'd0);

        $display("[TB] one-shot frame $010000-$010008");
        s = 23'h008000; e = 23'h008004;
        apply_stimulus(s, e);
        push_frame(s, e);
        cpu_write(4'd0, 8'h01);
        wait_idle("oneshot");
        cpu_read(4'd0, d);
        check_output("oneshot_play_cleared", 32'(d), 32'd0);
        read_addr(4'd4, v);
        check_output("oneshot_cnt_at_end", 32'(v), 32'({e, 1'b0}));

        $display("[TB] looped frame, loop released after two frames");
        push_frame(s, e);
        push_frame(s, e);
        push_frame(s, e);
        base = ints_seen;
        cpu_write(4'd0, 8'h03);
        n = 0;
        while (ints_seen < base + 2 && n < 2000) begin
            @(negedge clk32);
            n++;
        end
        check_output("loop_two_ints", 32'(ints_seen - base), 32'd2);
        cpu_write(4'd0, 8'h01);
        wait_idle("loop");
        check_output("loop_total_ints", 32'(ints_seen - base), 32'd3);

        $display("[TB] SREQ held low mid-frame");
        s = 23'h010000; e = 23'h010008;
        apply_stimulus(s, e);
        push_frame(s, e);
        base = loads_seen;
        cpu_write(4'd0, 8'h01);
        n = 0;
        while (loads_seen < base + 2 && n < 500) begin
            @(negedge clk32);
            n++;
        end
        sreq_level = 1'b0;
        repeat (8) @(negedge clk32);
        read_addr(4'd4, v);
        check_output("freeze_cnt", 32'(v), 32'({s + 23'(loads_seen - base), 1'b0}));
        r0 = req_cycles;
        repeat (44) @(negedge clk32);
        check_output("freeze_no_req", 32'(req_cycles - r0), 32'd0);
        read_addr(4'd4, v2);
        check_output("freeze_cnt_held", 32'(v2), 32'(v));
        sreq_level = 1'b1;
        wait_idle("freeze");

        $display("[TB] start == end, one-shot");
        s = 23'h010000;
        apply_stimulus(s, s);
        push_frame(s, s);
        r0 = req_cycles;
        cpu_write(4'd0, 8'h01);
        wait_idle("empty");
        check_output("empty_no_req", 32'(req_cycles - r0), 32'd0);
        cpu_read(4'd0, d);
        check_output("empty_play_cleared", 32'(d), 32'd0);

        $display("[TB] start == end, looping");
        free_int = 1'b1;
        cpu_write(4'd0, 8'h03);
        n = 0;
        while (!snd_int && n < 50) begin
            @(negedge clk32);
            n++;
        end
        check_output("empty_loop_first_int", 32'(snd_int), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk32);
            check_output("empty_loop_period", 32'(snd_int), 32'(i % 2 == 0));
        end
        cpu_write(4'd0, 8'h00);
        wait_idle("empty_loop");
        free_int = 1'b0;

        $display("[TB] play cleared during bus request");
        ack_force = 8;
        apply_stimulus(23'h020000, 23'h020004);
        cpu_write(4'd0, 8'h01);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk32);
            n++;
        end
        check_output("abort_req_seen", 32'(mem_req), 32'd1);
        cpu_write(4'd0, 8'h00);
        check_output("abort_req_held", 32'(mem_req), 32'd1);
        wait_idle("abort");
        ack_force = -1;

        $display("[TB] random frames");
        sreq_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin
                s = 23'h7FFFFE; e = 23'h000001;
            end else begin
                s = 23'($urandom);
                e = s + 23'($urandom_range(0, 6));
            end
            apply_stimulus(s, e);
            push_frame(s, e);
            cpu_write(4'd0, 8'h01);
            wait_idle("rand");
            read_addr(4'd4, v);
            check_output("rand_cnt_at_end", 32'(v), 32'({e, 1'b0}));
        end
        sreq_rand = 1'b0;

        $display("[TB] reset during bus request");
        ack_force = 10;
        apply_stimulus(23'h030000, 23'h030004);
        cpu_write(4'd0, 8'h01);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk32);
            n++;
        end
        check_output("rst_req_seen", 32'(mem_req), 32'd1);
        #2 resb = 1'b0;
        #1;
        check_output("rst_req_dropped", 32'(mem_req), 32'd0);
        check_output("rst_active_dropped", 32'(snd_active), 32'd0);
        cpu_read(4'd0, d);
        check_output("rst_ctrl_zero", 32'(d), 32'd0);
        read_addr(4'd4, v);
        check_output("rst_cnt_zero", 32'(v), 32'd0);
        read_addr(4'd1, v);
        check_output("rst_start_zero", 32'(v), 32'd0);
        @(negedge clk32);
        resb = 1'b1;
        repeat (15) @(negedge clk32);
        ack_force = -1;
        check_output("rst_stays_idle", 32'(snd_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
